// File: rtl/udp_rx_frame_buf.sv
// udp_rx_frame_buf: stores UDP payload bytes from the GMAC in a byte RAM and
// commits a frame only when it ends cleanly. A committed frame is replayed over
// a valid/ready byte stream, with its length and remote port alongside.
module udp_rx_frame_buf #(
  parameter int ADDR_W = 11,
  parameter int LQ_W   = 3
) (
  input  logic        clk125,
  input  logic        rst_n,
  input  logic        SOF_IN,
  input  logic        EOF_IN,
  input  logic        ENA_IN,
  input  logic        ERR_IN,
  input  logic [7:0]  DATA_IN,
  input  logic [15:0] PORT_IN,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [7:0]  m_data,
  output logic        m_sof,
  output logic        m_eof,
  output logic [15:0] m_len,
  output logic [15:0] m_port,
  output logic [31:0] frame_cnt,
  output logic [31:0] drop_cnt
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int QDEPTH = 1 << LQ_W;

  typedef logic [ADDR_W:0] ptr_t;
  typedef struct packed {
    logic [15:0]       len;
    logic [15:0]       port;
    logic [ADDR_W-1:0] addr;
  } desc_t;
  typedef enum logic [1:0] {W_IDLE, W_RX, W_DROP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_LOAD, R_SEND} r_state_t;

  localparam ptr_t              RAM_FULL = ptr_t'(DEPTH);
  localparam ptr_t              PTR_ONE  = ptr_t'(1);
  localparam logic [LQ_W:0]     Q_FULL   = (LQ_W + 1)'(QDEPTH);
  localparam logic [LQ_W:0]     LQ_ONE   = (LQ_W + 1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  logic [7:0] ram [DEPTH];
  desc_t      lq_mem [QDEPTH];

  // Write side
  w_state_t          w_state, w_next;
  ptr_t              wr_ptr, wr_ptr_n, wr_commit, wr_commit_n, rd_ptr;
  ptr_t              used, base_used;
  logic [16:0]       len, len_n, len_sum;
  logic              bad, bad_n, bad_end;
  logic [15:0]       port_q, port_n;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic              push;
  desc_t             push_desc;
  logic [1:0]        drop_inc;
  logic              commit_inc;
  logic [LQ_W:0]     lq_wr, lq_rd, lq_free, lq_used;
  logic              q_full, base_full;

  // Read side
  r_state_t          r_state, r_next;
  desc_t             head;
  logic              accept, eof_acc, q_avail, pop, a_move, fetch;
  logic [ADDR_W-1:0] fetch_addr;
  logic [15:0]       fetch_rem;
  logic              fetch_first;
  logic              a_valid, a_sof, a_eof;
  logic [7:0]        ram_q;

  assign used      = wr_ptr - rd_ptr;
  assign base_used = wr_commit - rd_ptr;
  assign base_full = (base_used == RAM_FULL);
  assign lq_used   = lq_wr - lq_free;
  assign q_full    = (lq_used == Q_FULL);
  assign len_sum   = len[16] ? len : len + 17'd1;
  assign bad_end   = bad | ERR_IN;

  // Write FSM next state: stores bytes, commits clean frames, rolls back the rest.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    w_next      = w_state;
    wr_ptr_n    = wr_ptr;
    wr_commit_n = wr_commit;
    len_n       = len;
    bad_n       = bad;
    port_n      = port_q;
    ram_we      = 1'b0;
    ram_waddr   = wr_ptr[ADDR_W-1:0];
    push        = 1'b0;
    push_desc   = '0;
    drop_inc    = 2'd0;
    commit_inc  = 1'b0;
    if (ENA_IN) begin
      if (SOF_IN) begin
        // An SOF inside an open frame truncates it; the new frame reuses its space.
        if (w_state != W_IDLE) drop_inc = 2'd1;
        wr_ptr_n = wr_commit;
        if (q_full || base_full) begin
          if (EOF_IN) begin
            drop_inc = drop_inc + 2'd1;
            w_next   = W_IDLE;
          end else begin
            w_next   = W_DROP;
          end
        end else begin
          ram_we    = 1'b1;
          ram_waddr = wr_commit[ADDR_W-1:0];
          port_n    = PORT_IN;
          len_n     = 17'd1;
          bad_n     = ERR_IN;
          if (EOF_IN) begin
            w_next = W_IDLE;
            if (ERR_IN) begin
              drop_inc = drop_inc + 2'd1;
            end else begin
              push        = 1'b1;
              push_desc   = '{len: 16'd1, port: PORT_IN, addr: wr_commit[ADDR_W-1:0]};
              wr_ptr_n    = wr_commit + PTR_ONE;
              wr_commit_n = wr_commit + PTR_ONE;
              commit_inc  = 1'b1;
            end
          end else begin
            wr_ptr_n = wr_commit + PTR_ONE;
            w_next   = W_RX;
          end
        end
      end else begin
        case (w_state)
          W_RX: begin
            if (used == RAM_FULL) begin
              // Overflow: reclaim the partial frame; an overflowing EOF beat ends it here.
              wr_ptr_n = wr_commit;
              if (EOF_IN) begin
                drop_inc = 2'd1;
                w_next   = W_IDLE;
              end else begin
                w_next   = W_DROP;
              end
            end else begin
              ram_we = 1'b1;
              if (EOF_IN) begin
                w_next = W_IDLE;
                if (bad_end || len_sum[16]) begin
                  wr_ptr_n = wr_commit;
                  drop_inc = 2'd1;
                end else begin
                  push        = 1'b1;
                  push_desc   = '{len: len_sum[15:0], port: port_q, addr: wr_commit[ADDR_W-1:0]};
                  wr_ptr_n    = wr_ptr + PTR_ONE;
                  wr_commit_n = wr_ptr + PTR_ONE;
                  commit_inc  = 1'b1;
                end
              end else begin
                wr_ptr_n = wr_ptr + PTR_ONE;
                len_n    = len_sum;
                bad_n    = bad_end;
              end
            end
          end
          W_DROP: begin
            if (EOF_IN) begin
              drop_inc = 2'd1;
              w_next   = W_IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Write-side state, pointers and counters.
  always_ff @(posedge clk125 or negedge rst_n) begin
    if (!rst_n) begin
      w_state   <= W_IDLE;
      wr_ptr    <= '0;
      wr_commit <= '0;
      len       <= '0;
      bad       <= 1'b0;
      port_q    <= '0;
      lq_wr     <= '0;
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      w_state   <= w_next;
      wr_ptr    <= wr_ptr_n;
      wr_commit <= wr_commit_n;
      len       <= len_n;
      bad       <= bad_n;
      port_q    <= port_n;
      if (push) lq_wr <= lq_wr + LQ_ONE;
      frame_cnt <= frame_cnt + 32'(commit_inc);
      drop_cnt  <= drop_cnt + 32'(drop_inc);
    end
  end

  // Data RAM and descriptor queue storage, plus the registered RAM read port.
  always_ff @(posedge clk125) begin
    // NOTE: storage arrays carry no reset; the pointers alone define what is valid.
    if (ram_we) ram[ram_waddr] <= DATA_IN;
    if (push) lq_mem[lq_wr[LQ_W-1:0]] <= push_desc;
    if (fetch) ram_q <= ram[fetch_addr];
  end

  assign head    = lq_mem[lq_rd[LQ_W-1:0]];
  assign q_avail = (lq_wr != lq_rd);
  assign accept  = m_valid & m_ready;
  assign eof_acc = accept & m_eof;
  assign pop     = q_avail && ((r_state == R_IDLE) || ((r_state == R_SEND) && eof_acc));
  // Stage A (ram_q) feeds the output register; it may refill as it drains.
  assign a_move  = a_valid & (~m_valid | m_ready);
  assign fetch   = (r_state != R_IDLE) && (fetch_rem != 16'd0) && (!a_valid || a_move);

  // Read FSM next state: load a descriptor, then stream its bytes.
  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (q_avail) r_next = R_LOAD;
      R_LOAD:  r_next = R_SEND;
      R_SEND:  if (eof_acc) r_next = q_avail ? R_LOAD : R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Read-side pipeline: fetch counter, prefetch stage and output register.
  always_ff @(posedge clk125 or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= R_IDLE;
      lq_rd       <= '0;
      lq_free     <= '0;
      rd_ptr      <= '0;
      fetch_addr  <= '0;
      fetch_rem   <= '0;
      fetch_first <= 1'b0;
      a_valid     <= 1'b0;
      a_sof       <= 1'b0;
      a_eof       <= 1'b0;
      m_valid     <= 1'b0;
      m_data      <= '0;
      m_sof       <= 1'b0;
      m_eof       <= 1'b0;
      m_len       <= '0;
      m_port      <= '0;
    end else begin
      r_state <= r_next;
      if (pop) begin
        lq_rd       <= lq_rd + LQ_ONE;
        fetch_addr  <= head.addr;
        fetch_rem   <= head.len;
        fetch_first <= 1'b1;
        m_len       <= head.len;
        m_port      <= head.port;
      end else if (fetch) begin
        fetch_addr  <= fetch_addr + ADDR_ONE;
        fetch_rem   <= fetch_rem - 16'd1;
        fetch_first <= 1'b0;
      end
      if (fetch) begin
        a_valid <= 1'b1;
        a_sof   <= fetch_first;
        a_eof   <= (fetch_rem == 16'd1);
      end else if (a_move) begin
        a_valid <= 1'b0;
      end
      if (a_move) begin
        m_valid <= 1'b1;
        m_data  <= ram_q;
        m_sof   <= a_sof;
        m_eof   <= a_eof;
      end else if (accept) begin
        m_valid <= 1'b0;
      end
      if (accept) rd_ptr <= rd_ptr + PTR_ONE;
      if (eof_acc) lq_free <= lq_free + LQ_ONE;
    end
  end

endmodule

// File: tb/tb_udp_rx_frame_buf.sv
// Directed bench for udp_rx_frame_buf: a default-size instance and a 64-byte
// instance share the input bus; each is enabled only during its own tests.
module tb_udp_rx_frame_buf;

  logic        clk125 = 1'b0;
  logic        rst_n;
  logic        sof, eof, err, ena_a, ena_b, m_ready;
  logic [7:0]  data;
  logic [15:0] port;

  logic        a_m_valid, a_m_sof, a_m_eof, b_m_valid, b_m_sof, b_m_eof;
  logic [7:0]  a_m_data, b_m_data;
  logic [15:0] a_m_len, a_m_port, b_m_len, b_m_port;
  logic [31:0] a_frame_cnt, a_drop_cnt, b_frame_cnt, b_drop_cnt;

  typedef struct {
    logic [7:0]  data;
    logic        sof;
    logic        eof;
    logic [15:0] len;
    logic [15:0] port;
    int          cyc;
  } beat_t;

  beat_t qa[$];
  beat_t qb[$];
  int    cyc = 0;
  int    first_valid_a = -1;
  int    eof_cyc = 0;
  int    n_cmp = 0;
  int    n_bad = 0;

  always #4 clk125 = ~clk125;

  always @(posedge clk125) cyc <= cyc + 1;

  udp_rx_frame_buf u_dut (
    .clk125(clk125), .rst_n(rst_n), .SOF_IN(sof), .EOF_IN(eof), .ENA_IN(ena_a),
    .ERR_IN(err), .DATA_IN(data), .PORT_IN(port),
    .m_valid(a_m_valid), .m_ready(m_ready), .m_data(a_m_data), .m_sof(a_m_sof),
    .m_eof(a_m_eof), .m_len(a_m_len), .m_port(a_m_port),
    .frame_cnt(a_frame_cnt), .drop_cnt(a_drop_cnt)
  );

  udp_rx_frame_buf #(.ADDR_W(6), .LQ_W(3)) u_small (
    .clk125(clk125), .rst_n(rst_n), .SOF_IN(sof), .EOF_IN(eof), .ENA_IN(ena_b),
    .ERR_IN(err), .DATA_IN(data), .PORT_IN(port),
    .m_valid(b_m_valid), .m_ready(m_ready), .m_data(b_m_data), .m_sof(b_m_sof),
    .m_eof(b_m_eof), .m_len(b_m_len), .m_port(b_m_port),
    .frame_cnt(b_frame_cnt), .drop_cnt(b_drop_cnt)
  );

  // Record every accepted output beat mid-cycle, away from the clock edge.
  always @(negedge clk125) begin
    beat_t bt;
    if (a_m_valid && first_valid_a < 0) first_valid_a = cyc;
    if (a_m_valid && m_ready) begin
      bt.data = a_m_data; bt.sof = a_m_sof; bt.eof = a_m_eof;
      bt.len = a_m_len; bt.port = a_m_port; bt.cyc = cyc;
      qa.push_back(bt);
    end
    if (b_m_valid && m_ready) begin
      bt.data = b_m_data; bt.sof = b_m_sof; bt.eof = b_m_eof;
      bt.len = b_m_len; bt.port = b_m_port; bt.cyc = cyc;
      qb.push_back(bt);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk125);
    #1;
  endtask

  task automatic beat(input logic s, input logic e, input logic er, input logic [7:0] d,
                      input logic [15:0] p, input logic to_b);
    sof = s; eof = e; err = er; data = d; port = p;
    ena_a = !to_b; ena_b = to_b;
    @(posedge clk125);
    #1;
    ena_a = 1'b0; ena_b = 1'b0; sof = 1'b0; eof = 1'b0; err = 1'b0;
  endtask

  task automatic frame(input int n, input logic [7:0] base, input logic [15:0] p,
                       input logic err_last, input logic to_b);
    for (int i = 0; i < n; i++)
      beat(i == 0, i == n - 1, err_last && (i == n - 1), 8'(base + i), p, to_b);
    eof_cyc = cyc;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(2);
    qa.delete();
    qb.delete();
    first_valid_a = -1;
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(a_m_valid), 32'd0);
    check({tag, "_data"},  32'(a_m_data),  32'd0);
    check({tag, "_sof"},   32'(a_m_sof),   32'd0);
    check({tag, "_eof"},   32'(a_m_eof),   32'd0);
    check({tag, "_len"},   32'(a_m_len),   32'd0);
    check({tag, "_port"},  32'(a_m_port),  32'd0);
    check({tag, "_fcnt"},  a_frame_cnt,    32'd0);
    check({tag, "_dcnt"},  a_drop_cnt,     32'd0);
  endtask

  initial begin
    rst_n = 1'b0; m_ready = 1'b1;
    sof = 1'b0; eof = 1'b0; err = 1'b0; ena_a = 1'b0; ena_b = 1'b0;
    data = '0; port = '0;
    idle(3);
    rst_n = 1'b1;
    idle(1);
    check_reset_outputs("rst");

    // Single good 64-byte frame, consumer always ready.
    frame(64, 8'h00, 16'h04D2, 1'b0, 1'b0);
    idle(80);
    check("t1_count", 32'(qa.size()), 32'd64);
    for (int i = 0; i < qa.size() && i < 64; i++) begin
      check("t1_data", 32'(qa[i].data), 32'(i));
      check("t1_flags", {30'd0, qa[i].sof, qa[i].eof}, {30'd0, i == 0, i == 63});
      check("t1_contig", 32'(qa[i].cyc - qa[0].cyc), 32'(i));
    end
    if (qa.size() > 0) begin
      check("t1_len", 32'(qa[0].len), 32'd64);
      check("t1_port", 32'(qa[0].port), 32'h04D2);
    end
    check("t1_latency", 32'(first_valid_a - eof_cyc), 32'd3);
    check("t1_fcnt", a_frame_cnt, 32'd1);
    check("t1_dcnt", a_drop_cnt, 32'd0);

    // Errored 20-byte frame followed by a good 10-byte frame.
    do_reset();
    frame(20, 8'h40, 16'h1111, 1'b1, 1'b0);
    frame(10, 8'h80, 16'h2222, 1'b0, 1'b0);
    idle(40);
    check("t2_count", 32'(qa.size()), 32'd10);
    for (int i = 0; i < qa.size() && i < 10; i++)
      check("t2_data", 32'(qa[i].data), 32'(8'h80 + i));
    if (qa.size() > 0) begin
      check("t2_len", 32'(qa[0].len), 32'd10);
      check("t2_port", 32'(qa[0].port), 32'h2222);
    end
    check("t2_fcnt", a_frame_cnt, 32'd1);
    check("t2_dcnt", a_drop_cnt, 32'd1);

    // Consumer stalled: 9 frames offered, 8 held, the 9th dropped.
    do_reset();
    m_ready = 1'b0;
    for (int f = 0; f < 9; f++) begin
      frame(8, 8'(f * 16), 16'(16'h1000 + f), 1'b0, 1'b0);
      idle(2);
    end
    idle(5);
    check("t3_fcnt", a_frame_cnt, 32'd8);
    check("t3_dcnt", a_drop_cnt, 32'd1);
    check("t3_hold_valid", 32'(a_m_valid), 32'd1);
    check("t3_hold_data", 32'(a_m_data), 32'h00);
    check("t3_hold_sof", 32'(a_m_sof), 32'd1);
    check("t3_hold_len", 32'(a_m_len), 32'd8);
    check("t3_hold_port", 32'(a_m_port), 32'h1000);
    m_ready = 1'b1;
    idle(120);
    check("t3_count", 32'(qa.size()), 32'd64);
    for (int i = 0; i < qa.size() && i < 64; i++) begin
      check("t3_data", 32'(qa[i].data), 32'((i / 8) * 16 + i % 8));
      check("t3_flags", {30'd0, qa[i].sof, qa[i].eof}, {30'd0, i % 8 == 0, i % 8 == 7});
      if (i % 8 == 0) check("t3_port", 32'(qa[i].port), 32'(16'h1000 + i / 8));
    end

    // 64-byte RAM instance: a 70-byte frame overflows, a 60-byte frame passes.
    do_reset();
    frame(70, 8'h00, 16'h3333, 1'b0, 1'b1);
    idle(5);
    check("t4_drop_dcnt", b_drop_cnt, 32'd1);
    check("t4_drop_fcnt", b_frame_cnt, 32'd0);
    check("t4_drop_out", 32'(qb.size()), 32'd0);
    frame(60, 8'h10, 16'h4444, 1'b0, 1'b1);
    idle(80);
    check("t4_count", 32'(qb.size()), 32'd60);
    for (int i = 0; i < qb.size() && i < 60; i++)
      check("t4_data", 32'(qb[i].data), 32'(8'h10 + i));
    if (qb.size() > 0) begin
      check("t4_len", 32'(qb[0].len), 32'd60);
      check("t4_port", 32'(qb[0].port), 32'h4444);
    end
    check("t4_fcnt", b_frame_cnt, 32'd1);
    check("t4_dcnt", b_drop_cnt, 32'd1);

    // SOF inside an open frame truncates it; only the new 3-byte frame survives.
    do_reset();
    beat(1'b1, 1'b0, 1'b0, 8'hE0, 16'h7777, 1'b0);
    for (int i = 1; i < 5; i++) beat(1'b0, 1'b0, 1'b0, 8'(8'hE0 + i), 16'h7777, 1'b0);
    frame(3, 8'hC0, 16'h5555, 1'b0, 1'b0);
    idle(30);
    check("t5_dcnt", a_drop_cnt, 32'd1);
    check("t5_fcnt", a_frame_cnt, 32'd1);
    check("t5_count", 32'(qa.size()), 32'd3);
    for (int i = 0; i < qa.size() && i < 3; i++)
      check("t5_data", 32'(qa[i].data), 32'(8'hC0 + i));
    if (qa.size() > 0) begin
      check("t5_len", 32'(qa[0].len), 32'd3);
      check("t5_port", 32'(qa[0].port), 32'h5555);
    end

    // One-byte frame: SOF and EOF on the same beat.
    do_reset();
    beat(1'b1, 1'b1, 1'b0, 8'hA5, 16'hBEEF, 1'b0);
    idle(10);
    check("t6_count", 32'(qa.size()), 32'd1);
    if (qa.size() > 0) begin
      check("t6_data", 32'(qa[0].data), 32'hA5);
      check("t6_sof", 32'(qa[0].sof), 32'd1);
      check("t6_eof", 32'(qa[0].eof), 32'd1);
      check("t6_len", 32'(qa[0].len), 32'd1);
      check("t6_port", 32'(qa[0].port), 32'hBEEF);
    end
    check("t6_fcnt", a_frame_cnt, 32'd1);

    // Reset while a frame is stalled at the output and another is arriving.
    do_reset();
    m_ready = 1'b0;
    frame(4, 8'h30, 16'h6666, 1'b0, 1'b0);
    idle(6);
    check("t7_pre_valid", 32'(a_m_valid), 32'd1);
    check("t7_pre_fcnt", a_frame_cnt, 32'd1);
    beat(1'b1, 1'b0, 1'b0, 8'h50, 16'h8888, 1'b0);
    beat(1'b0, 1'b0, 1'b0, 8'h51, 16'h8888, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t7_rst");
    idle(1);
    rst_n = 1'b1;
    qa.delete();
    beat(1'b0, 1'b0, 1'b0, 8'h52, 16'h8888, 1'b0);
    beat(1'b0, 1'b1, 1'b0, 8'h53, 16'h8888, 1'b0);
    m_ready = 1'b1;
    idle(10);
    check("t7_post_fcnt", a_frame_cnt, 32'd0);
    check("t7_post_dcnt", a_drop_cnt, 32'd0);
    check("t7_post_valid", 32'(a_m_valid), 32'd0);
    check("t7_post_count", 32'(qa.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/udp_rx_frame_buf.md
# udp_rx_frame_buf

Receive-side frame buffer on the `clk125` domain, fed by the custom GMAC's UDP payload output (`SOF_OUT`/`EOF_OUT`/`ENA_OUT`/`ERR_OUT`/`DATA_OUT`/`RemotePortOut`). It stores each incoming payload in a byte RAM and commits the frame only when it ends without error. Errored, truncated or overflowing frames are rolled back. Committed frames are replayed to the application over a valid/ready byte stream, with length and remote port presented alongside.

## Interface
- `ADDR_W`, 11, log2 of data RAM depth in bytes (2048).
- `LQ_W`, 3, log2 of frame-descriptor queue depth (8 frames).
- `clk125` in 1: sole clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `SOF_IN` in 1: first payload byte of a frame; valid only with `ENA_IN`.
- `EOF_IN` in 1: last payload byte of a frame; valid only with `ENA_IN`.
- `ENA_IN` in 1: byte strobe qualifying `DATA_IN`.
- `ERR_IN` in 1: frame bad (CRC/format); sampled on every `ENA_IN` beat of a frame.
- `DATA_IN` in 8: payload byte.
- `PORT_IN` in 16: remote UDP port; sampled on the SOF beat.
- `m_valid` out 1: output byte valid.
- `m_ready` in 1: consumer accepts the byte when `m_valid & m_ready`.
- `m_data` out 8: output byte.
- `m_sof` out 1: first byte of a frame.
- `m_eof` out 1: last byte of a frame.
- `m_len` out 16: byte count of the current frame; stable for the whole frame.
- `m_port` out 16: remote port of the current frame; stable for the whole frame.
- `frame_cnt` out 32: committed frames, wraps.
- `drop_cnt` out 32: dropped frames, wraps.

## Operation
- Write FSM states: `W_IDLE`, `W_RX`, `W_DROP`.
- `W_IDLE` + `ENA&SOF`:
  - If the descriptor queue is full or the RAM is full: go to `W_DROP`, or count the drop immediately if `EOF` is also high.
  - Otherwise write the byte at `wr_ptr`, latch `PORT_IN`, set `len=1`, set `bad=ERR_IN`, and go to `W_RX`.
- `W_IDLE` + `ENA` without `SOF`: ignore the byte. No counter changes.
- `W_RX` + `ENA`:
  - If used bytes (`wr_ptr - rd_ptr`, `ADDR_W+1` bits) equal `2^ADDR_W`: roll back and go to `W_DROP`.
  - Otherwise write the byte, `len++`, and `bad |= ERR_IN`.
- `W_RX` + `ENA&SOF`: the previous frame is truncated.
  - Roll it back and increment `drop_cnt`.
  - Start the new frame in the same cycle, applying the `W_IDLE` rules.
- Frame end, on the `EOF` beat in `W_RX` or a same-beat `SOF&EOF` in `W_IDLE`:
  - If `bad|ERR_IN` or `len` would exceed 65535: roll back and increment `drop_cnt`.
  - Otherwise push `{len, port, start address}` to the descriptor queue, set `wr_commit <= wr_ptr+1`, and increment `frame_cnt`.
  - Return to `W_IDLE`.
- `W_DROP`: discard bytes until the `EOF` beat. Then increment `drop_cnt` and go to `W_IDLE`. An `SOF` in `W_DROP` is treated as in `W_RX`.
- Rollback means `wr_ptr <= wr_commit`. Address arithmetic is modulo `2^ADDR_W`.
- Read FSM states: `R_IDLE`, `R_LOAD`, `R_SEND`.
  - `R_IDLE` + queue non-empty → `R_LOAD`: pop the descriptor and issue the RAM read of the start address.
  - `R_LOAD` → `R_SEND`: assert `m_valid` with `m_sof=1`.
  - In `R_SEND`, each accepted byte advances `rd_ptr`. The next byte must be available the following cycle, giving 1 byte/cycle when `m_ready` is held high (prefetch/skid register).
  - On acceptance of the `m_eof` byte: go to `R_LOAD` if the queue is non-empty, else `R_IDLE`.
- `m_eof` is asserted on byte index `m_len-1`. For `m_len=1`, `m_sof` and `m_eof` are both asserted.
- `m_data`/`m_sof`/`m_eof` hold while `m_valid & !m_ready`.
- Read and write proceed concurrently. Bytes freed by `rd_ptr` are usable by the writer the next cycle.

## Timing
- Reset values: `m_valid=0`, `m_data=0`, `m_sof=0`, `m_eof=0`, `m_len=0`, `m_port=0`, `frame_cnt=0`, `drop_cnt=0`. Both FSMs idle, all pointers 0, queue empty.
- Reset mid-frame discards all stored and in-flight frames. No counter increments.
- Input side never stalls; there is no back-pressure to the GMAC.
- Commit latency: the queue push is visible the cycle after the `EOF` edge. The first `m_valid` rises on the 3rd rising edge after the edge sampling `EOF`, provided the read side was idle.
- Counters update on the edge that samples the deciding `EOF`/`SOF`/overflow beat.
- Simultaneous queue push and pop in the same cycle is legal; occupancy is unchanged.

## Test plan
- Single good frame, 64 bytes `0x00..0x3F`, port `0x04D2`, `m_ready=1`:
  - Output bytes `0x00..0x3F` contiguous.
  - `m_sof` on `0x00`, `m_eof` on `0x3F`.
  - `m_len=64`, `m_port=0x04D2`.
  - `frame_cnt=1`, first `m_valid` 3 cycles after `EOF`.
- Frame of 20 bytes with `ERR_IN=1` on `EOF`, followed by a good 10-byte frame:
  - Only the 10-byte frame is output.
  - `drop_cnt=1`, `frame_cnt=1`, and the second frame starts at RAM address 0.
- `m_ready` held low, 9 good 8-byte frames sent: 8 frames are queued and the 9th is dropped (`drop_cnt=1`). Releasing `m_ready` then yields exactly 8 frames.
- `ADDR_W=6` build, a 70-byte frame: dropped on overflow, `drop_cnt=1`. A following 60-byte frame passes intact.
- `SOF` at byte 5 of an open frame, then a new frame of 3 bytes: `drop_cnt=1`, and the output is only the 3-byte frame.
- One-byte frame (`SOF=EOF=1`, data `0xA5`): the output beat has `m_sof=m_eof=1`, `m_len=1`, `m_data=0xA5`.
- Reset pulse mid-frame: all outputs return to reset values.
